// File: rtl/seg7_scan_if.sv
// Display bus monitored by the scan decoder, together with the decoded results.
// master = side that drives the multiplexed display lines (display driver / bench),
// slave  = the decoder, which watches seg/an and reports decoded state.
interface seg7_scan_if;
    logic [6:0]  seg;          // active-low segments, seg[0]=a .. seg[6]=g
    logic [3:0]  an;           // active-low digit anodes
    logic [15:0] value;        // decoded nibbles, digit i at [4*i+3:4*i]
    logic [3:0]  digit_valid;  // last capture of digit i was a legal hex pattern
    logic        frame_valid;  // pulse: frame of four legal digits completed
    logic        pattern_err;  // pulse: captured pattern neither hex nor blank
    logic [1:0]  err_digit;    // digit of the most recent illegal capture
    logic        stale;        // no capture for TIMEOUT_CYCLES

    modport master (
        output seg, an,
        input  value, digit_valid, frame_valid, pattern_err, err_digit, stale
    );

    modport slave (
        input  seg, an,
        output value, digit_valid, frame_valid, pattern_err, err_digit, stale
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for a 4-digit time-multiplexed 7-segment bus.
// Synchronizes seg/an, requires STABLE_CYCLES identical samples per dwell,
// decodes one capture per dwell into a hex nibble and tracks frames/timeouts.
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan_if.slave  bus
);
    localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [8:0]    STB    = 9'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    state_t        state, state_n;
    logic [7:0]    cnt, cnt_n;
    logic [6:0]    seg_m, s_seg, p_seg;
    logic [3:0]    an_m, s_an, p_an;
    logic          sel, same, capture;
    logic [1:0]    idx;
    logic [5:0]    dec;          // {legal, blank, nibble}
    logic [15:0]   value_q;
    logic [3:0]    dv_q, mask_q, ok_q, mask_n, ok_n;
    logic          fv_q, perr_q, stale_q;
    logic [1:0]    edig_q;
    logic [TW-1:0] idle_cnt;

    // Exact-match segment decode; anything else is an illegal pattern.
    function automatic logic [5:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = {2'b10, 4'h0};
            7'b1111001: decode = {2'b10, 4'h1};
            7'b0100100: decode = {2'b10, 4'h2};
            7'b0110000: decode = {2'b10, 4'h3};
            7'b0011001: decode = {2'b10, 4'h4};
            7'b0010010: decode = {2'b10, 4'h5};
            7'b0000010: decode = {2'b10, 4'h6};
            7'b1111000: decode = {2'b10, 4'h7};
            7'b0000000: decode = {2'b10, 4'h8};
            7'b0010000: decode = {2'b10, 4'h9};
            7'b0001000: decode = {2'b10, 4'hA};
            7'b0000011: decode = {2'b10, 4'hB};
            7'b1000110: decode = {2'b10, 4'hC};
            7'b0100001: decode = {2'b10, 4'hD};
            7'b0000110: decode = {2'b10, 4'hE};
            7'b0001110: decode = {2'b10, 4'hF};
            7'b1111111: decode = {2'b01, 4'h0};
            default:    decode = {2'b00, 4'h0};
        endcase
    endfunction

    // Two-flop synchronizers plus a copy of the previous synchronized sample.
    // Reset to all ones = bus idle (no digit selected, all segments dark).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m <= '1; s_seg <= '1; p_seg <= '1;
            an_m  <= '1; s_an  <= '1; p_an  <= '1;
        end else begin
            seg_m <= bus.seg; s_seg <= seg_m; p_seg <= s_seg;
            an_m  <= bus.an;  s_an  <= an_m;  p_an  <= s_an;
        end
    end

    // Digit selection: exactly one anode low.
    always_comb begin
        sel = 1'b1;
        idx = 2'd0;
        case (s_an)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: sel = 1'b0;
        endcase
    end

    assign same = ({s_an, s_seg} == {p_an, p_seg});
    assign dec  = decode(s_seg);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: a new or changed selection starts a dwell counting as the
    // first stable sample; capture fires once when the count reaches STABLE.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        if (!sel) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (state == IDLE || !same) begin
            cnt_n = 8'd1;
            if (STABLE_CYCLES == 1) begin
                capture = 1'b1;
                state_n = HELD;
            end else begin
                state_n = SETTLE;
            end
        end else if (state == SETTLE) begin
            if ({1'b0, cnt} + 9'd1 == STB) begin
                capture = 1'b1;
                state_n = HELD;
            end else begin
                cnt_n = cnt + 8'd1;
            end
        end
    end

    // Frame bookkeeping for the digit being captured this cycle.
    always_comb begin
        mask_n      = mask_q;
        ok_n        = ok_q;
        mask_n[idx] = 1'b1;
        ok_n[idx]   = dec[5];
    end

    // Output registers, frame tracking and idle timeout; capture beats timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q  <= '0; dv_q   <= '0; fv_q    <= 1'b0; perr_q <= 1'b0;
            edig_q   <= '0; stale_q <= 1'b0; mask_q <= '0; ok_q    <= '0;
            idle_cnt <= '0;
        end else begin
            fv_q   <= 1'b0;
            perr_q <= 1'b0;
            if (capture) begin
                idle_cnt <= '0;
                stale_q  <= 1'b0;
                dv_q[idx] <= dec[5];
                if (dec[5])
                    value_q[{idx, 2'b00} +: 4] <= dec[3:0];
                if (!dec[5] && !dec[4]) begin
                    perr_q <= 1'b1;
                    edig_q <= idx;
                end
                if (mask_n == 4'hF) begin
                    fv_q   <= (ok_n == 4'hF);
                    mask_q <= '0;
                    ok_q   <= '0;
                end else begin
                    mask_q <= mask_n;
                    ok_q   <= ok_n;
                end
            end else if (idle_cnt != TO_MAX) begin
                idle_cnt <= idle_cnt + TW'(1);
                if (idle_cnt == TO_MAX - TW'(1)) begin
                    stale_q <= 1'b1;
                    dv_q    <= '0;
                    mask_q  <= '0;
                end
            end
        end
    end

    assign bus.value       = value_q;
    assign bus.digit_valid = dv_q;
    assign bus.frame_valid = fv_q;
    assign bus.pattern_err = perr_q;
    assign bus.err_digit   = edig_q;
    assign bus.stale       = stale_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder (STABLE_CYCLES=4, TIMEOUT_CYCLES=50).
// Expected output snapshots are queued when a dwell is driven and popped on the
// edge where the capture must become visible.
module tb_seg7_scan_decoder;
    localparam int STABLE = 4;
    localparam int TO     = 50;
    localparam logic [6:0] PAT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dv;
        logic        fv;
        logic        perr;
        logic [1:0]  ed;
        logic        stale;
    } snap_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    snap_t sb[$];
    int    passed = 0;
    int    total = 0;

    seg7_scan_if bus();

    seg7_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic snap_t observe();
        return '{bus.value, bus.digit_valid, bus.frame_valid,
                 bus.pattern_err, bus.err_digit, bus.stale};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s);
        bus.an  = a;
        bus.seg = s;
    endtask

    task automatic test_reset();
        snap_t o;
        drive(4'hF, 7'h7F);
        rst_n = 1'b0;
        repeat (3) tick();
        o = observe();
        total++;
        if (o !== '0) $display("FAIL reset_state: got %h want 0", o);
        else passed++;
        rst_n = 1'b1;
        tick();
        o = observe();
        total++;
        if (o !== '0) $display("FAIL after_release: got %h want 0", o);
        else passed++;
    endtask

    task automatic test_single_digit();
        snap_t o, e;
        drive(4'b1110, PAT[2]);
        sb.push_back('{16'h0002, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0});
        for (int k = 1; k <= 10; k++) begin
            tick();
            o = observe();
            if (k == 5) begin
                total++;
                if (o.dv !== 4'b0000 || o.value !== 16'h0)
                    $display("FAIL single_early: value=%h dv=%b want 0000/0000", o.value, o.dv);
                else passed++;
            end
            if (k == 6) begin
                e = sb.pop_front();
                total++;
                if (o !== e) $display("FAIL single_capture: got %h want %h", o, e);
                else passed++;
            end
            if (k == 9) begin
                total++;
                if (o.fv !== 1'b0 || o.perr !== 1'b0)
                    $display("FAIL single_no_pulse: fv=%b perr=%b want 0 0", o.fv, o.perr);
                else passed++;
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0]  nib [4] = '{4'h3, 4'hA, 4'h0, 4'hF};
        logic [15:0] ev = 16'h0002;
        logic [3:0]  edv = 4'b0001;
        snap_t o, e;
        for (int d = 0; d < 4; d++) begin
            drive(~(4'b0001 << d), PAT[nib[d]]);
            ev[4*d +: 4] = nib[d];
            edv[d] = 1'b1;
            sb.push_back('{ev, edv, (d == 3), 1'b0, 2'd0, 1'b0});
            for (int k = 1; k <= 8; k++) begin
                tick();
                o = observe();
                if (k == 6) begin
                    e = sb.pop_front();
                    total++;
                    if (o !== e) $display("FAIL scan_d%0d: got %h want %h", d, o, e);
                    else passed++;
                end
                if (k == 7 && d == 3) begin
                    total++;
                    if (o.fv !== 1'b0) $display("FAIL scan_fv_pulse_width: fv=%b want 0", o.fv);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_pattern_err();
        logic [6:0] pats [4];
        logic [3:0] edvs [4] = '{4'b1111, 4'b1101, 4'b1101, 4'b1101};
        snap_t o, e;
        pats = '{PAT[3], 7'b1010101, PAT[0], PAT[15]};
        for (int d = 0; d < 4; d++) begin
            drive(~(4'b0001 << d), pats[d]);
            sb.push_back('{16'hF0A3, edvs[d], 1'b0, (d == 1), (d >= 1) ? 2'd1 : 2'd0, 1'b0});
            for (int k = 1; k <= 8; k++) begin
                tick();
                o = observe();
                if (k == 6) begin
                    e = sb.pop_front();
                    total++;
                    if (o !== e) $display("FAIL perr_d%0d: got %h want %h", d, o, e);
                    else passed++;
                end
                if (k == 7 && d == 1) begin
                    total++;
                    if (o.perr !== 1'b0 || o.ed !== 2'd1)
                        $display("FAIL perr_pulse: perr=%b ed=%0d want 0 1", o.perr, o.ed);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_blank();
        snap_t o, e;
        drive(4'b1101, PAT[10]);
        sb.push_back('{16'hF0A3, 4'b1111, 1'b0, 1'b0, 2'd1, 1'b0});
        repeat (6) tick();
        o = observe(); e = sb.pop_front();
        total++;
        if (o !== e) $display("FAIL blank_recover: got %h want %h", o, e);
        else passed++;
        tick(); tick();
        drive(4'b1011, 7'h7F);
        sb.push_back('{16'hF0A3, 4'b1011, 1'b0, 1'b0, 2'd1, 1'b0});
        repeat (6) tick();
        o = observe(); e = sb.pop_front();
        total++;
        if (o !== e) $display("FAIL blank_capture: got %h want %h", o, e);
        else passed++;
        tick(); tick();
    endtask

    task automatic test_short_dwell();
        snap_t o, e;
        int    moved = 0;
        sb.push_back('{16'hF0A3, 4'b1011, 1'b0, 1'b0, 2'd1, 1'b0});
        drive(4'b1110, PAT[8]);
        for (int k = 0; k < 26; k++) begin
            if (k == 3)  drive(4'b1101, PAT[8]);
            if (k == 6)  drive(4'b1100, PAT[8]);
            tick();
            if (observe() !== sb[0]) moved++;
        end
        total++;
        if (moved != 0) $display("FAIL short_dwell_stable: %0d changed cycles, want 0", moved);
        else passed++;
        o = observe(); e = sb.pop_front();
        total++;
        if (o !== e) $display("FAIL short_dwell_end: got %h want %h", o, e);
        else passed++;
    endtask

    task automatic test_timeout();
        logic [15:0] ev = 16'hF0A3;
        logic [3:0]  edv = 4'b1011;
        snap_t o, e;
        int    n = 0;
        for (int d = 0; d < 4; d++) begin
            drive(~(4'b0001 << d), PAT[d + 1]);
            ev[4*d +: 4] = 4'(d + 1);
            edv[d] = 1'b1;
            sb.push_back('{ev, edv, (d == 3), 1'b0, 2'd1, 1'b0});
            for (int k = 1; k <= 8; k++) begin
                tick();
                if (k == 6) begin
                    o = observe(); e = sb.pop_front();
                    total++;
                    if (o !== e) $display("FAIL frame2_d%0d: got %h want %h", d, o, e);
                    else passed++;
                end
            end
        end
        n = 2;
        drive(4'hF, 7'h7F);
        sb.push_back('{16'h4321, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b1});
        while (n < 60) begin
            tick();
            n++;
            o = observe();
            if (n == TO - 1) begin
                total++;
                if (o.stale !== 1'b0 || o.dv !== 4'b1111)
                    $display("FAIL stale_early: stale=%b dv=%b want 0 1111", o.stale, o.dv);
                else passed++;
            end
            if (n == TO) begin
                e = sb.pop_front();
                total++;
                if (o !== e) $display("FAIL stale_set: got %h want %h", o, e);
                else passed++;
            end
        end
        drive(4'b1110, PAT[5]);
        sb.push_back('{16'h4325, 4'b0001, 1'b0, 1'b0, 2'd1, 1'b0});
        for (int k = 1; k <= 8; k++) begin
            tick();
            o = observe();
            if (k == 5) begin
                total++;
                if (o.stale !== 1'b1) $display("FAIL stale_hold: stale=%b want 1", o.stale);
                else passed++;
            end
            if (k == 6) begin
                e = sb.pop_front();
                total++;
                if (o !== e) $display("FAIL stale_clear: got %h want %h", o, e);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_dwell();
        snap_t o, e;
        drive(4'b1101, PAT[6]);
        repeat (3) tick();
        rst_n = 1'b0;
        #2;
        o = observe();
        total++;
        if (o !== '0) $display("FAIL async_reset: got %h want 0", o);
        else passed++;
        tick(); tick();
        rst_n = 1'b1;
        sb.push_back('{16'h0060, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b0});
        for (int k = 1; k <= 7; k++) begin
            tick();
            o = observe();
            if (k == 5) begin
                total++;
                if (o !== '0) $display("FAIL redwell_early: got %h want 0", o);
                else passed++;
            end
            if (k == 6) begin
                e = sb.pop_front();
                total++;
                if (o !== e) $display("FAIL redwell_capture: got %h want %h", o, e);
                else passed++;
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_digit();
        test_scan();
        test_pattern_err();
        test_blank();
        test_short_dwell();
        test_timeout();
        test_reset_mid_dwell();
        total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Receive-side counterpart of the team's hex-to-7-segment encoders. Monitors a time-multiplexed 4-digit Basys3-style display bus (seg/an, both active-low), filters glitches and ghosting, and decodes each digit's segment pattern back into a hex nibble. Reconstructs the 16-bit displayed value with per-digit validity and frame/error flags. Used as a self-check monitor beside display drivers and as a bench/debug decoder.

Parameters:
STABLE_CYCLES, 4, consecutive identical synchronized samples required before a digit is captured (1..255)
TIMEOUT_CYCLES, 1000000, cycles with no capture before the stale flag is raised (>= 2)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
seg  input  7  segment lines, active-low; seg[0]=a ... seg[6]=g
an  input  4  digit anodes, active-low; an[i]=0 selects digit i
value  output  16  decoded nibbles; digit i at value[4*i+3:4*i]
digit_valid  output  4  bit i = last capture of digit i decoded to a legal hex pattern
frame_valid  output  1  one-cycle pulse: a full frame of 4 valid digits completed
pattern_err  output  1  one-cycle pulse: captured pattern is neither hex nor blank
err_digit  output  2  index of last illegal capture; held until next error
stale  output  1  level: no capture for TIMEOUT_CYCLES

Behaviour:
- Reset (async on rst_n low): value=0, digit_valid=0, frame_valid=0, pattern_err=0, err_digit=0, stale=0, sync flops=all ones, counters=0, frame mask=0, state=IDLE.
- seg and an each pass a 2-flop synchronizer; all logic uses synchronized values (s_seg, s_an).
- Digit selected: s_an has exactly one zero; index = that bit position. Zero or multiple zeros = no selection.
- FSM:
  IDLE: no selection. On selection -> SETTLE, cnt=1.
  SETTLE: same {s_an,s_seg} as previous cycle -> cnt++; when cnt==STABLE_CYCLES -> capture, -> HELD. Any change -> cnt=1 (stay SETTLE) if still selected, else IDLE.
  HELD: one capture per dwell. Change with selection -> SETTLE, cnt=1; loss of selection -> IDLE.
- Latency: inputs constant from edge t -> captured outputs visible after edge t+STABLE_CYCLES+2 (2 sync, STABLE_CYCLES-1 filter, 1 output register).
- Decode table (s_seg, exact match, hex): 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9, 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F.
- Capture outcomes for digit i:
  legal hex: value nibble i updated, digit_valid[i]=1.
  blank (1111111): digit_valid[i]=0, nibble unchanged, no error.
  other: digit_valid[i]=0, nibble unchanged, pattern_err pulses, err_digit=i.
- Frame tracking: mask bit i set on any capture of digit i; frame_ok bit i = outcome legal. Re-capture of digit i in same frame overwrites frame_ok[i], mask unchanged. Capture completing mask=1111: frame_valid pulses same cycle as output update iff frame_ok==1111; mask and frame_ok clear that cycle regardless.
- Timeout: idle counter cleared on each capture, saturates at TIMEOUT_CYCLES; on reaching it: stale=1, digit_valid=0, mask=0. stale clears on next capture (same cycle as its output update).
- Simultaneous capture and timeout: capture wins; counter clears, stale stays/returns 0.
- rst_n low mid-dwell: immediate return to reset values; after release a fresh STABLE_CYCLES dwell is required.

Test Plan:
- STABLE_CYCLES=4: hold an=1110, seg=0100100 for 10 cycles -> value[3:0]=2, digit_valid=0001 exactly 6 edges after input change; no pulses.
- Scan digits 0..3 with patterns for 3,A,0,F, 8 cycles each -> value=16'hF0A3, digit_valid=1111, frame_valid single pulse with digit 3 update.
- Digit 1 pattern 1010101 -> pattern_err one-cycle pulse, err_digit=1, digit_valid[1]=0, frame_valid suppressed for that frame.
- Dwell of 3 cycles (< STABLE_CYCLES) then switch, and an=1100 for 20 cycles -> no capture, outputs unchanged.
- TIMEOUT_CYCLES=50, bus idle (an=1111) for 60 cycles after valid frame -> stale=1 at cycle 50, digit_valid=0000; next valid capture clears stale.
- rst_n pulsed low mid-dwell -> all outputs 0 asynchronously; capture only after full re-dwell post-release.
